// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: per-channel idle-timeout clock gating; `define CLOCK_GATE_TEST_BYPASS_EN adds test_en_i to force all gated clocks on
module clock_gate_ctrl_ld_1 (
    input  logic d_i,
    input  logic g_i,
    output logic q_o
);
    always_latch if (!g_i) q_o <= d_i;
endmodule

module clock_gate_ctrl #(
    parameter int NUM_CH           = 4,
    parameter int IDLE_CYCLES      = 8,
    parameter bit BEHAVIORAL_LATCH = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              gating_en_i,
`ifdef CLOCK_GATE_TEST_BYPASS_EN
    input  logic              test_en_i,
`endif
    input  logic [NUM_CH-1:0] busy_i,
    output logic [NUM_CH-1:0] gated_clk_o,
    output logic [NUM_CH-1:0] clk_on_o
);
    localparam int CW     = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam int LAST_I = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    typedef enum logic [1:0] {ST_ON, ST_IDLE, ST_OFF} state_e;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] latch_d;
    assign clk_on_o = en_q;
`ifdef CLOCK_GATE_TEST_BYPASS_EN
    assign latch_d = en_q | {NUM_CH{test_en_i}};
`else
    assign latch_d = en_q;
`endif
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e        state_q;
        logic [CW-1:0] cnt_q;
        logic          en_bit_q;
        logic          latch_q;
        assign en_q[c] = en_bit_q;
        always_ff @(posedge clk_i) begin
            if (rst_i || !gating_en_i) begin
                state_q  <= ST_ON;
                cnt_q    <= '0;
                en_bit_q <= 1'b1;
            end else if (busy_i[c]) begin
                state_q  <= ST_ON;
                cnt_q    <= '0;
                en_bit_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_ON: begin
                        state_q  <= (IDLE_CYCLES == 0) ? ST_OFF : ST_IDLE;
                        cnt_q    <= '0;
                        en_bit_q <= (IDLE_CYCLES != 0);
                    end
                    ST_IDLE: begin
                        if (cnt_q == LAST) begin
                            state_q  <= ST_OFF;
                            en_bit_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q  <= ST_OFF;
                        en_bit_q <= 1'b0;
                    end
                endcase
            end
        end
        // latch opaque while clk_i is high, so enable changes never clip a high phase
        if (BEHAVIORAL_LATCH) begin : g_beh
            always_latch if (!clk_i) latch_q <= latch_d[c];
        end else begin : g_prim
            clock_gate_ctrl_ld_1 u_ld (.d_i(latch_d[c]), .g_i(clk_i), .q_o(latch_q));
        end
        assign gated_clk_o[c] = latch_q & clk_i;
    end
endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently gated clock channels (1..32).
REQ-002 SHALL have parameter IDLE_CYCLES, default 8: consecutive idle cycles before a channel is gated (0..255).
REQ-003 SHALL have parameter BEHAVIORAL_LATCH, default 1: 1 = inferred level latch; 0 = LD_1 primitive per channel.
REQ-004 SHALL have port clk_i  input  1  free-running source clock.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-006 SHALL have port gating_en_i  input  1  global gating enable; 0 forces all channels on.
REQ-007 SHALL have port busy_i  input  NUM_CH  per-channel activity request, sampled at posedge clk_i.
REQ-008 SHALL have port gated_clk_o  output  NUM_CH  per-channel gated clock.
REQ-009 SHALL have port clk_on_o  output  NUM_CH  registered per-channel enable (en_q), also the status view.

Function
REQ-010 Each channel SHALL run an independent FSM with states ON, IDLE, OFF and an idle counter of width $clog2(IDLE_CYCLES+1), minimum 1.
REQ-011 ON->IDLE when busy_i[n]=0; counter cleared to 0.
REQ-012 IDLE: counter increments each cycle busy_i[n]=0; IDLE->ON when busy_i[n]=1 (counter cleared); IDLE->OFF when busy_i[n]=0 and counter = IDLE_CYCLES-1.
REQ-013 OFF->ON when busy_i[n]=1; OFF holds otherwise.
REQ-014 IDLE_CYCLES=0: ON->OFF directly when busy_i[n]=0; IDLE is unreachable.
REQ-015 busy_i[n]=1 SHALL take priority over any gating transition in the same cycle.
REQ-016 en_q[n] SHALL be 1 in ON and IDLE, 0 in OFF, registered at posedge clk_i; clk_on_o = en_q.
REQ-017 gated_clk_o[n] SHALL equal latch_q[n] AND clk_i, where latch_q[n] is transparent while clk_i is low and loads en_q[n]; glitch-free, no truncated high phases.
REQ-018 Wake latency: busy_i[n] sampled high at edge k in OFF -> en_q[n]=1 after edge k -> first gated rising edge at edge k+1.
REQ-019 Gate latency: en_q[n] falls after edge k -> edge k is the last gated rising edge; no edge k+1.
REQ-020 gating_en_i=0 SHALL force every FSM to ON (counter 0) at the next edge, overriding busy_i; on return to 1, channels resume from ON.
REQ-021 Channels SHALL NOT interact; simultaneous transitions on all channels SHALL be legal.

Reset
REQ-022 rst_i=1 at a posedge SHALL set every FSM to ON, counters to 0, en_q to all-ones, so clk_on_o = all-ones.
REQ-023 gated_clk_o SHALL toggle with clk_i throughout reset so downstream synchronous resets complete.
REQ-024 Reset asserted mid-countdown or in OFF SHALL take effect at the next edge regardless of busy_i or gating_en_i.

Configuration
REQ-025 Macro CLOCK_GATE_TEST_BYPASS_EN defined: SHALL add input test_en_i (1 bit); latch D = en_q[n] OR test_en_i, forcing all gated clocks on in test mode; FSMs and clk_on_o unaffected.
REQ-026 Macro undefined: SHALL omit port test_en_i; latch D = en_q[n]; no other change.

Verification
REQ-027 Reset: rst_i=1 for 3 cycles, busy_i=0 -> clk_on_o=4'hF, all gated_clk_o toggle during and 1 cycle after reset.
REQ-028 Idle timeout: NUM_CH=4, IDLE_CYCLES=8, busy_i=4'h0 after reset -> clk_on_o[n]=0 exactly 9 edges after reset release (1 ON->IDLE + 8 count); no gated edges afterwards.
REQ-029 Late wake: ch0 in IDLE with counter=7 and busy_i[0]=1 -> stays ON, clk_on_o[0]=1, no gated-edge gap.
REQ-030 Wake: ch2 OFF, busy_i[2]=1 sampled at edge k -> clk_on_o[2]=1 after k, first gated_clk_o[2] rise at k+1; other channels unchanged.
REQ-031 Override: all OFF, gating_en_i=0 -> clk_on_o=4'hF next edge; gating_en_i=1, busy_i=0 -> all OFF 9 edges later.
REQ-032 Bypass (macro defined): all OFF, test_en_i=1 -> all gated_clk_o follow clk_i from next low phase, clk_on_o remains 4'h0.
